// File: rtl/cache_nway_if.sv
// cache_nway_if: CPU request port and AXI-bridge port of the cache
interface cache_nway_if #(parameter int LINE_WORDS = 4) ();
  logic                    valid, uncache, op;
  logic [31:0]             addr, wdata, rdata;
  logic [3:0]              wstrb;
  logic                    addr_ok, data_ok;
  logic                    rd_req, rd_rdy;
  logic [2:0]              rd_type;
  logic [31:0]             rd_addr;
  logic                    ret_valid, ret_last;
  logic [31:0]             ret_data;
  logic                    wr_req, wr_rdy;
  logic [2:0]              wr_type;
  logic [31:0]             wr_addr;
  logic [3:0]              wr_wstrb;
  logic [32*LINE_WORDS-1:0] wr_data;
  modport slave (
    input  valid, uncache, op, addr, wstrb, wdata, rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
    output addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data
  );
  modport master (
    output valid, uncache, op, addr, wstrb, wdata, rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
    input  addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data
  );
endinterface

// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative write-back blocking cache with round-robin victim choice
module cache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input logic         clk,
  input logic         reset,
  cache_nway_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int WRD_W = OFF_W - 2;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REPLACE, REFILL} state_t;
  typedef logic [LINE_WORDS-1:0][31:0] line_t;
  state_t                        state_q, state_d;
  logic [WAYS-1:0][SETS-1:0]     v_q, v_d, d_q, d_d;
  logic [SETS-1:0][WAY_W-1:0]    ptr_q, ptr_d;
  logic [TAG_W-1:0]              tag_q [WAYS][SETS];
  logic [TAG_W-1:0]              tag_d [WAYS][SETS];
  line_t                         data_q [WAYS][SETS];
  line_t                         data_d [WAYS][SETS];
  logic                          op_q, op_d, unc_q, unc_d;
  logic [31:0]                   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]                    wstrb_q, wstrb_d;
  logic [WAY_W-1:0]              vic_way_q, vic_way_d;
  logic                          vic_v_q, vic_v_d, vic_dirty_q, vic_dirty_d;
  logic [TAG_W-1:0]              vic_tag_q, vic_tag_d;
  line_t                         vic_data_q, vic_data_d;
  logic [WRD_W-1:0]              cnt_q, cnt_d;
  logic [TAG_W-1:0]              tag_r;
  logic [IDX_W-1:0]              idx;
  logic [WRD_W-1:0]              off;
  logic                          hit, inv;
  logic [WAY_W-1:0]              hit_way, inv_way, victim;
  logic                          ok;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction
  assign tag_r  = addr_q[31 -: TAG_W];
  assign idx    = addr_q[OFF_W +: IDX_W];
  assign off    = addr_q[2 +: WRD_W];
  assign victim = inv ? inv_way : ptr_q[idx];
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (v_q[w][idx] && tag_q[w][idx] == tag_r) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!v_q[w][idx]) begin
        inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    d_d = d_q;
    ptr_d = ptr_q;
    tag_d = tag_q;
    data_d = data_q;
    op_d = op_q;
    unc_d = unc_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    vic_way_d = vic_way_q;
    vic_v_d = vic_v_q;
    vic_dirty_d = vic_dirty_q;
    vic_tag_d = vic_tag_q;
    vic_data_d = vic_data_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.valid) begin
        op_d = bus.op;
        unc_d = bus.uncache;
        addr_d = bus.addr;
        wdata_d = bus.wdata;
        wstrb_d = bus.wstrb;
        state_d = LOOKUP;
      end
      LOOKUP: if (unc_q) state_d = MISS;
      else if (hit) begin
        if (op_q) begin
          data_d[hit_way][idx][off] = merge(data_q[hit_way][idx][off], wdata_q, wstrb_q);
          d_d[hit_way][idx] = 1'b1;
        end
        state_d = IDLE;
      end else begin
        vic_way_d = victim;
        vic_v_d = v_q[victim][idx];
        vic_dirty_d = v_q[victim][idx] && d_q[victim][idx];
        vic_tag_d = tag_q[victim][idx];
        vic_data_d = data_q[victim][idx];
        state_d = MISS;
      end
      MISS: if (bus.wr_rdy) state_d = (unc_q && op_q) ? IDLE : REPLACE;
      REPLACE: if (bus.rd_rdy) begin
        cnt_d = '0;
        state_d = REFILL;
      end
      REFILL: if (bus.ret_valid) begin
        cnt_d = cnt_q + 1'b1;
        if (unc_q) state_d = IDLE;
        else begin
          data_d[vic_way_q][idx][cnt_q] = (op_q && cnt_q == off) ? merge(bus.ret_data, wdata_q, wstrb_q) : bus.ret_data;
          if (bus.ret_last) begin
            tag_d[vic_way_q][idx] = tag_r;
            v_d[vic_way_q][idx] = 1'b1;
            d_d[vic_way_q][idx] = op_q;
            if (vic_v_q) ptr_d[idx] = (WAYS == 1) ? '0 : ptr_q[idx] + 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      v_q <= '0;
      d_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      d_q <= d_d;
      ptr_q <= ptr_d;
      tag_q <= tag_d;
      data_q <= data_d;
      op_q <= op_d;
      unc_q <= unc_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      vic_way_q <= vic_way_d;
      vic_v_q <= vic_v_d;
      vic_dirty_q <= vic_dirty_d;
      vic_tag_q <= vic_tag_d;
      vic_data_q <= vic_data_d;
      cnt_q <= cnt_d;
    end
  end
  assign ok = !reset && ((state_q == LOOKUP && !unc_q && hit) ||
              (state_q == MISS && bus.wr_rdy && unc_q && op_q) ||
              (state_q == REFILL && bus.ret_valid && (unc_q || (op_q ? bus.ret_last : cnt_q == off))));
  assign bus.addr_ok  = !reset && state_q == IDLE;
  assign bus.data_ok  = ok;
  assign bus.rdata    = !ok ? '0 : state_q == LOOKUP ? data_q[hit_way][idx][off] : bus.ret_data;
  assign bus.rd_req   = !reset && state_q == REPLACE;
  assign bus.rd_type  = !bus.rd_req ? 3'b000 : unc_q ? 3'b010 : 3'b100;
  assign bus.rd_addr  = !bus.rd_req ? '0 : unc_q ? {addr_q[31:2], 2'b00} : {addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign bus.wr_req   = !reset && state_q == MISS && bus.wr_rdy && (unc_q ? op_q : vic_dirty_q);
  assign bus.wr_type  = !bus.wr_req ? 3'b000 : !unc_q ? 3'b100 :
                        $countones(wstrb_q) == 4 ? 3'b010 : $countones(wstrb_q) == 2 ? 3'b001 : 3'b000;
  assign bus.wr_addr  = !bus.wr_req ? '0 : unc_q ? addr_q : {vic_tag_q, idx, {OFF_W{1'b0}}};
  assign bus.wr_wstrb = !bus.wr_req ? 4'h0 : unc_q ? wstrb_q : 4'hF;
  assign bus.wr_data  = !bus.wr_req ? '0 : unc_q ? (32*LINE_WORDS)'(wdata_q) : vic_data_q;
endmodule
